// File: rtl/axi_riscv_lrsc_table.sv
// LR/SC reservation table: tracks per-ID reservations on address granules and answers SC requests.
// Optional per-entry reservation lifetime enabled by defining AXI_RISCV_LRSC_TIMEOUT_EN.
module axi_riscv_lrsc_table #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned NUM_RES        = 4,
    parameter int unsigned GRANULE_LSB    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           lr_valid_i,
    output logic                           lr_ready_o,
    input  logic [ID_WIDTH-1:0]            lr_id_i,
    input  logic [ADDR_WIDTH-1:0]          lr_addr_i,
    input  logic                           sc_valid_i,
    output logic                           sc_ready_o,
    input  logic [ID_WIDTH-1:0]            sc_id_i,
    input  logic [ADDR_WIDTH-1:0]          sc_addr_i,
    output logic                           sc_rsp_valid_o,
    output logic                           sc_rsp_ok_o,
    input  logic                           sc_rsp_ready_i,
    input  logic                           wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    output logic [$clog2(NUM_RES+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(NUM_RES + 1);
    localparam int unsigned VW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    // Granules are kept as full-width addresses with the offset bits forced to zero.
    localparam logic [ADDR_WIDTH-1:0] GMASK = {ADDR_WIDTH{1'b1}} << GRANULE_LSB;

    if (NUM_RES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi_riscv_lrsc_table: NUM_RES and TIMEOUT_CYCLES must be at least 1");
    end

    logic [NUM_RES-1:0]    valid_q, valid_d;
    logic [ID_WIDTH-1:0]   id_q   [NUM_RES];
    logic [ID_WIDTH-1:0]   id_d   [NUM_RES];
    logic [ADDR_WIDTH-1:0] gran_q [NUM_RES];
    logic [ADDR_WIDTH-1:0] gran_d [NUM_RES];
    logic [VW-1:0]         victim_q, victim_d;
    logic                  ready_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_ok_q, rsp_ok_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  lr_acc, sc_acc, sc_ok;
    logic [ADDR_WIDTH-1:0] lr_gran, sc_gran, wr_gran;
    logic                  hit, free;
    logic [VW-1:0]         hit_idx, free_idx, lr_idx;
    logic [NUM_RES-1:0]    expire;

`ifdef AXI_RISCV_LRSC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q [NUM_RES];
    logic [TW-1:0] cnt_d [NUM_RES];
`endif

    assign lr_ready_o     = ready_q;
    assign sc_ready_o     = ready_q & ~rsp_valid_q;
    assign sc_rsp_valid_o = rsp_valid_q;
    assign sc_rsp_ok_o    = rsp_ok_q;
    assign count_o        = count_q;

    // Next table state: expiry, snoop and SC kills use the old state; LR is applied last.
    always_comb begin
        valid_d     = valid_q;
        id_d        = id_q;
        gran_d      = gran_q;
        victim_d    = victim_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ok_d    = rsp_ok_q;
        count_d     = '0;
        expire      = '0;
        sc_ok       = 1'b0;
        hit         = 1'b0;
        hit_idx     = '0;
        free        = 1'b0;
        free_idx    = '0;
        lr_idx      = '0;
        lr_acc      = lr_valid_i & ready_q;
        sc_acc      = sc_valid_i & ready_q & ~rsp_valid_q;
        lr_gran     = lr_addr_i & GMASK;
        sc_gran     = sc_addr_i & GMASK;
        wr_gran     = wr_addr_i & GMASK;
`ifdef AXI_RISCV_LRSC_TIMEOUT_EN
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_RES; i++) begin
            expire[i] = valid_q[i] && (cnt_q[i] == TW'(1));
            if (valid_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - TW'(1);
        end
`endif

        for (int unsigned i = 0; i < NUM_RES; i++) begin
            if (valid_q[i] && !expire[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran)
                sc_ok = 1'b1;
        end
        if (wr_valid_i && wr_gran == sc_gran) sc_ok = 1'b0;

        valid_d = valid_q & ~expire;
        for (int unsigned i = 0; i < NUM_RES; i++) begin
            if (wr_valid_i && valid_q[i] && gran_q[i] == wr_gran) valid_d[i] = 1'b0;
            if (sc_acc && valid_q[i] && id_q[i] == sc_id_i) valid_d[i] = 1'b0;
            if (!hit && valid_q[i] && id_q[i] == lr_id_i) begin
                hit     = 1'b1;
                hit_idx = VW'(i);
            end
            if (!free && !valid_q[i]) begin
                free     = 1'b1;
                free_idx = VW'(i);
            end
        end

        if (lr_acc) begin
            if (hit) begin
                lr_idx = hit_idx;
            end else if (free) begin
                lr_idx = free_idx;
            end else begin
                lr_idx   = victim_q;
                victim_d = (victim_q == VW'(NUM_RES - 1)) ? '0 : victim_q + VW'(1);
            end
            valid_d[lr_idx] = 1'b1;
            id_d[lr_idx]    = lr_id_i;
            gran_d[lr_idx]  = lr_gran;
`ifdef AXI_RISCV_LRSC_TIMEOUT_EN
            cnt_d[lr_idx]   = TW'(TIMEOUT_CYCLES);
`endif
        end

        if (rsp_valid_q && sc_rsp_ready_i) rsp_valid_d = 1'b0;
        if (sc_acc) begin
            rsp_valid_d = 1'b1;
            rsp_ok_d    = sc_ok;
        end

        for (int unsigned i = 0; i < NUM_RES; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            victim_q    <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            count_q     <= '0;
            for (int unsigned i = 0; i < NUM_RES; i++) begin
                id_q[i]   <= '0;
                gran_q[i] <= '0;
`ifdef AXI_RISCV_LRSC_TIMEOUT_EN
                cnt_q[i]  <= '0;
`endif
            end
        end else begin
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            ready_q     <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            count_q     <= count_d;
            id_q        <= id_d;
            gran_q      <= gran_d;
`ifdef AXI_RISCV_LRSC_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule
